// File: rtl/pe_stream_pkg.sv
// pe_stream_pkg
//   Definitions shared by the PE stream blocks (IF writer and IF reader):
//   - stream_state_e : writer FSM states
//   - IF_END_BIT / IF_START_BIT : flag positions in a tagged IF word,
//     given for the default data width and re-based to any width by the
//     if_end_bit()/if_start_bit() helpers so both sides agree.
package pe_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } stream_state_e;

  // Tagged word layout: {start_flag, end_flag, data[IF_DATA_WIDTH-1:0]}
  localparam int IF_DATA_WIDTH = 8;
  localparam int IF_END_BIT    = IF_DATA_WIDTH;
  localparam int IF_START_BIT  = IF_DATA_WIDTH + 1;

  // Flag positions for an arbitrary data width, keeping the same offsets
  // above the data field as the localparams above.
  function automatic int if_end_bit(input int data_width);
    return data_width + (IF_END_BIT - IF_DATA_WIDTH);
  endfunction

  function automatic int if_start_bit(input int data_width);
    return data_width + (IF_START_BIT - IF_DATA_WIDTH);
  endfunction

endpackage

// File: rtl/if_buf_writer_if.sv
// if_buf_writer_if
//   Stream signals of the IF buffer writer.
//   Source side : src_valid, src_data (into the writer), src_ready (out).
//   Buffer side : buf_full (into the writer), buf_write, buf_wdata (out).
//   master modport : the writer itself.
//   slave  modport : the surrounding fetch path / IF buffer.
interface if_buf_writer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  src_valid;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_ready;
  logic                  buf_full;
  logic                  buf_write;
  logic [DATA_WIDTH+1:0] buf_wdata;

  modport master (
    input  src_valid, src_data, buf_full,
    output src_ready, buf_write, buf_wdata
  );

  modport slave (
    output src_valid, src_data, buf_full,
    input  src_ready, buf_write, buf_wdata
  );
endinterface

// File: rtl/if_buf_writer_tagged_hold_reg.sv
// tagged_hold_reg
//   One-entry hold register for tagged IF words.
//   Ports:
//     clk, rstn   : clock, asynchronous active-low reset (discards the word)
//     load        : capture load_word this edge (wins over drain, so a
//                   simultaneous drain+load refills without a bubble)
//     drain       : the held word was consumed this edge
//     load_word   : word to capture
//     hold_valid  : register holds a word
//     hold_word   : the held word
module tagged_hold_reg #(
  parameter int WORD_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic                  drain,
  input  logic [WORD_WIDTH-1:0] load_word,
  output logic                  hold_valid,
  output logic [WORD_WIDTH-1:0] hold_word
);

  logic                  valid_q, valid_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;

  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    if (load) begin
      valid_d = 1'b1;
      word_d  = load_word;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end

  assign hold_valid = valid_q;
  assign hold_word  = word_q;

endmodule

// File: rtl/if_buf_writer.sv
// if_buf_writer
//   Producer-side writer for a PE input-feature buffer. Accepts row_len x
//   num_rows source words per job, tags each with start/end-of-row flags
//   and pushes them into the IF FIFO through a one-entry hold register.
//   Ports:
//     clk, rstn          : clock, asynchronous active-low reset
//     start              : job start, only looked at while idle
//     row_len, num_rows  : job geometry, latched at start
//     bus (master)       : src_valid/src_data/src_ready source handshake,
//                          buf_full/buf_write/buf_wdata buffer write port
//     busy               : job in progress
//     done               : one-cycle pulse after the final buffer write
module if_buf_writer
  import pe_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] row_len,
  input  logic [LEN_WIDTH-1:0] num_rows,
  if_buf_writer_if.master      bus,
  output logic                 busy,
  output logic                 done
);

  localparam int WORD_WIDTH = DATA_WIDTH + 2;
  localparam int END_BIT    = if_end_bit(DATA_WIDTH);
  localparam int START_BIT  = if_start_bit(DATA_WIDTH);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  stream_state_e        state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] rows_q, rows_d;
  logic [LEN_WIDTH-1:0] col_q, col_d;
  logic [LEN_WIDTH-1:0] row_q, row_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                  hold_valid;
  logic [WORD_WIDTH-1:0] hold_word;
  logic [WORD_WIDTH-1:0] tag_word;
  logic                  src_fire;
  logic                  col_last;
  logic                  row_last;

  // Ready looks at buf_full directly: a full hold register can still take
  // a new word in the same edge it is written out.
  assign bus.src_ready = (state_q == STREAM) & (~hold_valid | ~bus.buf_full);
  assign bus.buf_write = hold_valid & ~bus.buf_full;
  assign bus.buf_wdata = hold_word;

  assign src_fire = bus.src_valid & bus.src_ready;
  assign col_last = (col_q == len_q - LEN_ONE);
  assign row_last = (row_q == rows_q - LEN_ONE);

  always_comb begin
    tag_word                   = '0;
    tag_word[DATA_WIDTH-1:0]   = bus.src_data;
    tag_word[START_BIT]        = (col_q == '0);
    tag_word[END_BIT]          = col_last;
  end

  tagged_hold_reg #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_hold (
    .clk        (clk),
    .rstn       (rstn),
    .load       (src_fire),
    .drain      (bus.buf_write),
    .load_word  (tag_word),
    .hold_valid (hold_valid),
    .hold_word  (hold_word)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rows_d  = rows_q;
    col_d   = col_q;
    row_d   = row_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = row_len;
          rows_d  = num_rows;
          col_d   = '0;
          row_d   = '0;
          // An empty job completes without touching the buffer.
          state_d = ((row_len != '0) && (num_rows != '0)) ? STREAM : DONE;
        end
      end
      STREAM: begin
        if (src_fire) begin
          if (col_last) begin
            col_d = '0;
            if (row_last) begin
              state_d = DRAIN;
            end else begin
              row_d = row_q + LEN_ONE;
            end
          end else begin
            col_d = col_q + LEN_ONE;
          end
        end
      end
      DRAIN: begin
        // The last word is in the hold register; finish once it is written.
        if (bus.buf_write) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      len_q   <= '0;
      rows_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rows_q  <= rows_d;
      col_q   <= col_d;
      row_q   <= row_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_if_buf_writer.sv
// tb_if_buf_writer
//   Directed bench for if_buf_writer. The reference is a queue of expected
//   tagged words built from the job geometry and the source data; a monitor
//   compares every buffer write and the done pulse against it each cycle.
module tb_if_buf_writer;

  localparam int DW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [LW-1:0] row_len;
  logic [LW-1:0] num_rows;
  logic          busy;
  logic          done;

  if_buf_writer_if #(.DATA_WIDTH(DW)) bus ();

  if_buf_writer #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .row_len  (row_len),
    .num_rows (num_rows),
    .bus      (bus.master),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0]   src_q[$];
  logic [DW+1:0]   exp_q[$];
  logic [1:0]      flag_log[$];
  logic [DW-1:0]   data_log[$];
  int              wr_cyc[$];
  int              cyc = 0;
  int              wr_cnt = 0;
  int              acc_cnt = 0;
  int              ready_hi_cnt = 0;
  bit              mon_en = 1'b0;
  bit              exp_done_now = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // exp holds n 2-bit flag pairs, first write in the most significant pair.
  task automatic chk_flags(input string name, input int n, input logic [15:0] exp);
    chk({name, "_count"}, flag_log.size(), n);
    for (int i = 0; i < n && i < flag_log.size(); i++) begin
      chk($sformatf("%s_%0d", name, i), flag_log[i], exp[2*(n-1-i) +: 2]);
    end
  endtask

  task automatic clear_logs();
    flag_log.delete();
    data_log.delete();
    wr_cyc.delete();
    wr_cnt = 0;
  endtask

  // Queue source data and the words the buffer must receive, then pulse start.
  task automatic launch(input int len, input int rows, input int base);
    for (int k = 0; k < len * rows; k++) begin
      logic [DW-1:0] d;
      logic          sf;
      logic          ef;
      d  = DW'(base + k);
      sf = ((k % len) == 0);
      ef = ((k % len) == len - 1);
      src_q.push_back(d);
      exp_q.push_back({sf, ef, d});
    end
    @(posedge clk); #1;
    start    = 1'b1;
    row_len  = LW'(len);
    num_rows = LW'(rows);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk(name, seen, 1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Source driver: presents the head of src_q whenever it has data.
  initial begin
    bus.src_valid = 1'b0;
    bus.src_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (src_q.size() > 0) begin
        bus.src_valid = 1'b1;
        bus.src_data  = src_q[0];
      end else begin
        bus.src_valid = 1'b0;
        bus.src_data  = '0;
      end
    end
  end

  // Monitor / compare process, samples mid-cycle.
  initial begin
    forever begin
      bit next_done;
      @(negedge clk);
      if (mon_en && rstn) begin
        next_done = 1'b0;
        if (bus.buf_write) begin
          chk("no_write_when_full", bus.buf_full, 0);
          chk("write_expected", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            logic [DW+1:0] w;
            w = exp_q.pop_front();
            chk("wdata", bus.buf_wdata, w);
            if (exp_q.size() == 0) next_done = 1'b1;
          end
          wr_cnt++;
          flag_log.push_back(bus.buf_wdata[DW+1:DW]);
          data_log.push_back(bus.buf_wdata[DW-1:0]);
          wr_cyc.push_back(cyc);
          $display("[TB] write #%0d flags=%b data=0x%02h", wr_cnt,
                   bus.buf_wdata[DW+1:DW], bus.buf_wdata[DW-1:0]);
        end
        // An empty job seen at start in idle completes on the next cycle.
        if (start && !busy && (row_len == '0 || num_rows == '0)) next_done = 1'b1;
        chk("done_timing", done, exp_done_now);
        exp_done_now = next_done;
        if (bus.src_valid && bus.src_ready) begin
          acc_cnt++;
          if (src_q.size() > 0) void'(src_q.pop_front());
        end
        if (bus.src_ready) ready_hi_cnt++;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int w0;
    bit reached;
    bus.buf_full = 1'b0;
    rstn     = 1'b0;
    start    = 1'b0;
    row_len  = '0;
    num_rows = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_src_ready", bus.src_ready, 0);
    chk("rst_buf_write", bus.buf_write, 0);
    chk("rst_buf_wdata", bus.buf_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    rstn   = 1'b1;
    mon_en = 1'b1;

    // 4 x 2 job, free-flowing
    clear_logs();
    launch(4, 2, 'h20);
    @(negedge clk);
    chk("t1_busy_s1", busy, 1);
    chk("t1_ready_s1", bus.src_ready, 1);
    wait_done("t1_done", 40);
    chk("t1_writes", wr_cnt, 8);
    chk_flags("t1_flags", 8, 16'b10_00_00_01_10_00_00_01);
    if (wr_cyc.size() == 8) chk("t1_back_to_back", wr_cyc[7] - wr_cyc[0], 7);
    else chk("t1_back_to_back_n", wr_cyc.size(), 8);

    // 1 x 3 job: every word is both start and end of its row
    clear_logs();
    launch(1, 3, 'h30);
    wait_done("t2_done", 30);
    chk_flags("t2_flags", 3, 16'b11_11_11);

    // Buffer full for 5 cycles in the middle of an 8-word row
    clear_logs();
    launch(8, 1, 'h10);
    repeat (2) @(posedge clk);
    #1 bus.buf_full = 1'b1;
    w0 = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_ready_stalled", bus.src_ready, 0);
      chk("t3_write_stalled", bus.buf_write, 0);
    end
    chk("t3_no_writes_in_stall", wr_cnt, w0);
    @(posedge clk); #1 bus.buf_full = 1'b0;
    wait_done("t3_done", 40);
    chk("t3_writes", data_log.size(), 8);
    for (int i = 0; i < 8 && i < data_log.size(); i++) begin
      chk($sformatf("t3_order_%0d", i), data_log[i], 8'h10 + i);
    end

    // Zero rows: done at S+1, no traffic
    clear_logs();
    ready_hi_cnt = 0;
    launch(4, 0, 0);
    @(negedge clk);
    chk("t4_done_s1", done, 1);
    chk("t4_busy_s1", busy, 1);
    @(negedge clk);
    chk("t4_busy_s2", busy, 0);
    chk("t4_done_s2", done, 0);
    repeat (3) @(negedge clk);
    chk("t4_writes", wr_cnt, 0);
    chk("t4_ready_never", ready_hi_cnt, 0);

    // Reset after the 3rd accepted word of a 4 x 2 job
    clear_logs();
    a0 = acc_cnt;
    launch(4, 2, 'h40);
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      @(posedge clk);
      if (acc_cnt >= a0 + 3) reached = 1'b1;
    end
    chk("t5_third_accept", reached, 1);
    #1 rstn = 1'b0;
    #1;
    chk("t5_rst_src_ready", bus.src_ready, 0);
    chk("t5_rst_buf_write", bus.buf_write, 0);
    chk("t5_rst_buf_wdata", bus.buf_wdata, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    src_q.delete();
    exp_q.delete();
    exp_done_now = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_idle_after_rst", busy, 0);
    clear_logs();
    launch(2, 1, 'h50);
    wait_done("t5_done", 20);
    chk_flags("t5_flags", 2, 16'b10_01);

    // Second start while streaming must be ignored
    clear_logs();
    launch(3, 2, 'h60);
    @(posedge clk); #1;
    start    = 1'b1;
    row_len  = LW'(5);
    num_rows = LW'(5);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t6_done", 40);
    repeat (6) @(negedge clk);
    chk("t6_writes", wr_cnt, 6);
    chk("t6_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_buf_writer.md
# if_buf_writer

Producer-side writer for the PE input-feature (IF) buffer: consumes a raw feature-map word stream, tags each word with row start/end flags, and pushes tagged words into the IF FIFO that the PE datapath's IF reader drains. It emits `num_rows` rows of `row_len` words each per job. Each tagged word is `{start_flag, end_flag, data}`; the IF reader keys scratchpad windows off the end flag. The block sits between the global-buffer fetch path and the IF buffer of one PE.

## Interface
Parameters:
- `DATA_WIDTH`, 8, feature data width; buffer word is `DATA_WIDTH+2` bits.
- `LEN_WIDTH`, 8, width of row-length and row-count fields and their counters.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  job start, sampled only in IDLE.
- `row_len`  in  LEN_WIDTH  words per row, latched at start.
- `num_rows`  in  LEN_WIDTH  rows per job, latched at start.
- `src_valid`  in  1  source word valid.
- `src_data`  in  DATA_WIDTH  source word.
- `src_ready`  out  1  block accepts `src_data` this cycle.
- `buf_full`  in  1  IF buffer full.
- `buf_write`  out  1  write strobe to IF buffer.
- `buf_wdata`  out  DATA_WIDTH+2  bit DATA_WIDTH+1 = start_flag, bit DATA_WIDTH = end_flag, low bits = data.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle job-complete pulse.

## Operation
- FSM states and transitions:
  - IDLE → STREAM on `start`, when the latched `row_len` and `num_rows` are both nonzero.
  - IDLE → DONE on `start`, when either latched value is zero. No writes occur.
  - STREAM → DRAIN when the last word of the last row is accepted.
  - DRAIN → DONE when the hold register is written to the buffer.
  - DONE → IDLE after one cycle.
- `start` while busy is ignored. Latched lengths are stable for the whole job.
- Counters:
  - `col_cnt` runs 0..`row_len`-1 and wraps to 0 at end of row; on wrap, `row_cnt` increments (0..`num_rows`-1).
  - A source handshake is `src_valid & src_ready`.
- Tagging of each accepted word:
  - start_flag = (`col_cnt`==0).
  - end_flag = (`col_cnt`==`row_len`-1).
  - `row_len`==1 gives both flags set.
- One-entry hold register (`hold_valid`, `hold_word`):
  - `src_ready` = STREAM & (!`hold_valid` | !`buf_full`).
  - `buf_write` = `hold_valid` & !`buf_full`. A write is counted only when accepted; no write strobe is issued into a full buffer.
  - A simultaneous drain and accept reloads the hold register in the same edge, so there is no bubble.
- Reset mid-job: FSM returns to IDLE, counters clear, and the hold word is discarded. No `done` pulse follows.

## Timing
- Reset values: `src_ready`=0, `buf_write`=0, `buf_wdata`=0, `busy`=0, `done`=0.
- `start` at edge S: `busy` and `src_ready` are high in cycle S+1.
- Latency: a word accepted at edge N appears on `buf_wdata` with `buf_write` high in cycle N+1 if `buf_full`=0. It holds there until `buf_full`=0.
- Throughput is 1 word/cycle while `buf_full`=0 and `src_valid`=1.
- `src_ready` depends combinationally on `buf_full`. `buf_write` and `buf_wdata` depend only on registers and `buf_full`.
- `done` is high for exactly the cycle after the final accepted buffer write.
- In the zero-length case, `done` is high in cycle S+1 and `busy` is high only during that cycle.

## Structure
- Shared package `pe_stream_pkg`:
  - state enum (IDLE, STREAM, DRAIN, DONE);
  - `IF_END_BIT` and `IF_START_BIT` localparams, expressed relative to `DATA_WIDTH`.
- The IF reader imports the same package so flag positions have one definition.
- One sub-module: `tagged_hold_reg`. It holds the hold register and valid bit, exposes load/drain, and is reset by `rstn`.

## Test plan
- `row_len`=4, `num_rows`=2, source always valid, `buf_full`=0 → 8 consecutive writes:
  - `buf_wdata` flags are 10,00,00,01,10,00,00,01;
  - `done` is high one cycle after the 8th write.
- `row_len`=1, `num_rows`=3 → 3 writes, each with flags 11.
- `buf_full` held high for 5 cycles mid-row:
  - `buf_write`=0 throughout;
  - `src_ready`=0 after one word is captured;
  - the held word is written first when `buf_full` drops, with no loss or duplication (data 0x10..0x17 arrives in order).
- `num_rows`=0 → `done` in cycle S+1, no `buf_write`, `src_ready` never high.
- `rstn` asserted after the 3rd accepted word of a 4×2 job → all outputs 0 immediately. A new `start` with `row_len`=2, `num_rows`=1 then yields flags 10,01.
- `start` pulsed again during STREAM → ignored; the write count still equals the original `row_len`×`num_rows`.
